// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX->MEM pipeline register: control bit positions,
// occupancy state encoding and the default control width.
package ex_mem_pkg;

  localparam int MEMREAD  = 0;
  localparam int MEMTOREG = 1;
  localparam int MEMWRITE = 2;
  localparam int REGWRITE = 3;

  localparam int CTRL_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; 1-cycle update latency, no backpressure.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM stage register with 2-entry skid; 1-cycle latency, 1/cycle throughput.
// Backpressure: ex_ready comes straight from state flops, so mem_ready never reaches it combinationally.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_aluout,
  input  logic [DATA_W-1:0] ex_regout,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [CTRL_W-1:0] ex_ctrl,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_aluout,
  output logic [DATA_W-1:0] mem_regout,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_aluout;
  logic [DATA_W-1:0] skid_regout;
  logic [ADDR_W-1:0] skid_waddr;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              main_valid;
  logic              skid_valid;
  logic              in_fire;
  logic              out_fire;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == TWO);
  assign ex_ready   = !skid_valid;
  assign in_fire    = ex_valid && ex_ready;
  assign out_fire   = main_valid && mem_ready;

  assign mem_valid  = main_valid;
  // A bubble must never look like a memory or register-file write.
  assign mem_ctrl   = main_valid ? main_ctrl : '0;
  assign occupancy  = 2'(main_valid) + 2'(skid_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      mem_aluout  <= '0;
      mem_regout  <= '0;
      mem_waddr   <= '0;
      main_ctrl   <= '0;
      skid_aluout <= '0;
      skid_regout <= '0;
      skid_waddr  <= '0;
      skid_ctrl   <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            mem_aluout <= ex_aluout;
            mem_regout <= ex_regout;
            mem_waddr  <= ex_waddr;
            main_ctrl  <= ex_ctrl;
            state      <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            mem_aluout <= ex_aluout;
            mem_regout <= ex_regout;
            mem_waddr  <= ex_waddr;
            main_ctrl  <= ex_ctrl;
          end else if (in_fire) begin
            skid_aluout <= ex_aluout;
            skid_regout <= ex_regout;
            skid_waddr  <= ex_waddr;
            skid_ctrl   <= ex_ctrl;
            state       <= TWO;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            mem_aluout <= skid_aluout;
            mem_regout <= skid_regout;
            mem_waddr  <= skid_waddr;
            main_ctrl  <= skid_ctrl;
            state      <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (main_valid && !mem_ready),
    .count (stall_cnt)
  );

endmodule
